// File: rtl/scope_trigger_capture.sv
// Triggered circular sample-capture buffer: pre-trigger window, level-crossing trigger, post-trigger window, frozen readout.
// Optional auto-trigger timeout is enabled with the SCOPE_AUTO_TRIG_EN macro.
module scope_trigger_capture #(
   parameter int ADDR_W       = 9,
   parameter int PRE_TRIG     = 128,
   parameter int AUTO_TIMEOUT = 4096
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [11:0]       sample_in,
   input  logic              sample_valid,
   input  logic [11:0]       trig_level,
   input  logic              trig_slope,
   input  logic              arm,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [11:0]       rd_data,
   output logic              busy,
   output logic              capture_done,
   output logic              trig_forced
);

   localparam int                DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]   PRE_N   = (ADDR_W + 1)'(PRE_TRIG);
   localparam logic [ADDR_W:0]   POST_N  = (ADDR_W + 1)'(DEPTH - PRE_TRIG);
   localparam logic [ADDR_W-1:0] PRE_OFS = ADDR_W'(PRE_TRIG);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PRETRIG = 3'd1,
      S_WAIT    = 3'd2,
      S_POST    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t            r_state;
   logic [11:0]       r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_trig_ptr;
   logic [ADDR_W:0]   r_pre_cnt;
   logic [ADDR_W:0]   r_post_cnt;
   logic [11:0]       r_prev;
   logic [11:0]       r_rd_data;
   logic              r_busy;
   logic              r_done;

   logic              w_active;
   logic              w_we;
   logic              w_arm_ok;
   logic              w_rise;
   logic              w_fall;
   logic              w_cross;
   logic              w_forced;
   logic              w_fire;
   logic [ADDR_W:0]   w_pre_nxt;
   logic [ADDR_W:0]   w_post_nxt;
   logic [ADDR_W-1:0] w_rd_phys;

   assign w_active   = (r_state == S_PRETRIG) || (r_state == S_WAIT) || (r_state == S_POST);
   assign w_we       = w_active && sample_valid;
   assign w_arm_ok   = arm && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_rise     = (r_prev < trig_level) && (sample_in >= trig_level);
   assign w_fall     = (r_prev > trig_level) && (sample_in <= trig_level);
   assign w_cross    = trig_slope ? w_rise : w_fall;
   assign w_fire     = w_cross || w_forced;
   assign w_pre_nxt  = r_pre_cnt + CNT_ONE;
   assign w_post_nxt = r_post_cnt + CNT_ONE;
   // Logical index 0 is the oldest sample, PRE_TRIG places before the trigger sample.
   assign w_rd_phys  = r_trig_ptr - PRE_OFS + rd_addr;

`ifdef SCOPE_AUTO_TRIG_EN
   localparam int              TO_W   = $clog2(AUTO_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_N   = TO_W'(AUTO_TIMEOUT);
   localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_trig_forced;

   assign w_forced    = ((r_to_cnt + TO_ONE) == TO_N) && !w_cross;
   assign trig_forced = r_trig_forced;

   // Timeout counter: held clear during PRETRIG so it starts at zero on WAIT_TRIG entry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_to_cnt      <= '0;
         r_trig_forced <= 1'b0;
      end else begin
         if (r_state == S_PRETRIG) begin
            r_to_cnt <= '0;
         end else if ((r_state == S_WAIT) && sample_valid) begin
            r_to_cnt <= r_to_cnt + TO_ONE;
         end else begin
            r_to_cnt <= r_to_cnt;
         end
         if (w_arm_ok) begin
            r_trig_forced <= 1'b0;
         end else if ((r_state == S_WAIT) && sample_valid && w_forced) begin
            r_trig_forced <= 1'b1;
         end else begin
            r_trig_forced <= r_trig_forced;
         end
      end
   end
`else
   logic w_unused_cfg;

   assign w_unused_cfg = |AUTO_TIMEOUT;
   assign w_forced     = 1'b0;
   assign trig_forced  = 1'b0;
`endif

   // Capture sequencer with registered status outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_trig_ptr <= '0;
         r_pre_cnt  <= '0;
         r_post_cnt <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  r_state    <= S_PRETRIG;
                  r_wr_ptr   <= '0;
                  r_pre_cnt  <= '0;
                  r_post_cnt <= '0;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
               end
            end
            S_PRETRIG: begin
               if (sample_valid) begin
                  r_wr_ptr  <= r_wr_ptr + PTR_ONE;
                  r_pre_cnt <= w_pre_nxt;
                  if (w_pre_nxt == PRE_N) begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (sample_valid) begin
                  r_wr_ptr <= r_wr_ptr + PTR_ONE;
                  if (w_fire) begin
                     r_trig_ptr <= r_wr_ptr;
                     r_post_cnt <= CNT_ONE;
                     if (POST_N == CNT_ONE) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_POST;
                     end
                  end
               end
            end
            S_POST: begin
               if (sample_valid) begin
                  r_wr_ptr   <= r_wr_ptr + PTR_ONE;
                  r_post_cnt <= w_post_nxt;
                  if (w_post_nxt == POST_N) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Previous-sample register for edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_prev <= '0;
      end else if ((r_state != S_IDLE) && sample_valid) begin
         r_prev <= sample_in;
      end else begin
         r_prev <= r_prev;
      end
   end

   // Sample storage; contents deliberately survive reset.
   always_ff @(posedge clock) begin
      if (w_we) begin
         r_mem[r_wr_ptr] <= sample_in;
      end
   end

   // Registered readout; a same-cycle write returns the old word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[w_rd_phys];
      end
   end

   assign rd_data      = r_rd_data;
   assign busy         = r_busy;
   assign capture_done = r_done;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Self-checking bench for scope_trigger_capture (DEPTH 16, PRE_TRIG 4, AUTO_TIMEOUT 8).
module tb_scope_trigger_capture;

   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int PRE   = 4;
   localparam int POSTN = DEPTH - PRE;
   localparam int AUTO  = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [11:0]   sample_in = '0;
   logic          sample_valid = 1'b0;
   logic [11:0]   trig_level = '0;
   logic          trig_slope = 1'b0;
   logic          arm = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [11:0]   rd_data;
   logic          busy;
   logic          capture_done;
   logic          trig_forced;

   int            total = 0;
   int            bad = 0;
   logic [11:0]   stim[$];
   bit            exp_forced;

   scope_trigger_capture #(.ADDR_W(AW), .PRE_TRIG(PRE), .AUTO_TIMEOUT(AUTO)) dut (
      .clock(clock), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .trig_level(trig_level), .trig_slope(trig_slope), .arm(arm), .rd_addr(rd_addr),
      .rd_data(rd_data), .busy(busy), .capture_done(capture_done), .trig_forced(trig_forced)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit crosses(logic [11:0] p, logic [11:0] c);
      if (trig_slope) return (p < trig_level) && (c >= trig_level);
      return (p > trig_level) && (c <= trig_level);
   endfunction

   // Index (into stim) of the trigger sample, or -1 if none.
   function automatic int model_trig();
      exp_forced = 1'b0;
      for (int i = PRE; i < stim.size(); i++) begin
         if (crosses(stim[i-1], stim[i])) return i;
`ifdef SCOPE_AUTO_TRIG_EN
         if (i == PRE + AUTO - 1) begin
            exp_forced = 1'b1;
            return i;
         end
`endif
      end
      return -1;
   endfunction

   task automatic ramp(input int start, input int step, input int n);
      int v;
      stim.delete();
      for (int i = 0; i < n; i++) begin
         v = start + step * i;
         if (v > 4095) v = 4095;
         if (v < 0) v = 0;
         stim.push_back(12'(v));
      end
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   // gap <= 0 selects random spacing of 1..4 cycles.
   task automatic capture(input int gap, input int arm_after, input int stop_at, output int done_at);
      int g;
      done_at = -1;
      for (int i = 0; i < stim.size(); i++) begin
         sample_in    = stim[i];
         sample_valid = 1'b1;
         tick();
         sample_valid = 1'b0;
         if (capture_done) begin
            done_at = i;
            break;
         end
         if (i == stop_at) break;
         g = (gap > 0) ? gap : int'($urandom_range(4, 1));
         for (int k = 1; k < g; k++) begin
            arm = (i == arm_after) && (k == 1);
            tick();
         end
         arm = 1'b0;
      end
   endtask

   task automatic verify(input string tag, input int gap, input int arm_after);
      int t;
      int d;
      int expd;
      t    = model_trig();
      expd = (t >= 0 && t + POSTN - 1 < stim.size()) ? t + POSTN - 1 : -1;
      pulse_arm();
      check({tag, "_busy_arm"}, 32'(busy), 32'd1);
      check({tag, "_done_arm"}, 32'(capture_done), 32'd0);
      capture(gap, arm_after, -1, d);
      check({tag, "_done_idx"}, d, expd);
      if (expd >= 0) begin
         check({tag, "_forced"}, 32'(trig_forced), 32'(exp_forced));
         check({tag, "_busy_done"}, 32'(busy), 32'd0);
         for (int k = 0; k < DEPTH; k++) begin
            rd_addr = AW'(k);
            tick();
            check($sformatf("%s_rd%0d", tag, k), 32'(rd_data), 32'(stim[t - PRE + k]));
         end
      end
   endtask

   initial begin
      int d;
      #2 reset = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(capture_done), 32'd0);
      check("rst_forced", 32'(trig_forced), 32'd0);
      check("rst_rd", 32'(rd_data), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // Rising trigger on a ramp.
      trig_level = 12'd1000; trig_slope = 1'b1;
      ramp(0, 100, 40);
      verify("rise", 3, -1);

      // Falling trigger on a descending ramp.
      trig_level = 12'd2000; trig_slope = 1'b0;
      ramp(3000, -100, 40);
      verify("fall", 3, -1);

      // Crossing inside the pre-trigger window must be ignored.
      trig_level = 12'd150; trig_slope = 1'b1;
      ramp(0, 100, 100);
      verify("pretrig", 3, -1);
`ifndef SCOPE_AUTO_TRIG_EN
      check("pretrig_busy_hold", 32'(busy), 32'd1);
      check("pretrig_done_hold", 32'(capture_done), 32'd0);
`endif
      do_reset();

      // Long low hold wraps the write pointer before the step.
      trig_level = 12'd1000; trig_slope = 1'b1;
      stim.delete();
      for (int i = 0; i < 40; i++) stim.push_back(12'($urandom_range(999, 0)));
      stim.push_back(12'd1500);
      for (int i = 0; i < 11; i++) stim.push_back(12'($urandom_range(4095, 0)));
      verify("wrap", 3, -1);

      // Asynchronous reset during the post-trigger window.
      ramp(0, 100, 40);
      pulse_arm();
      capture(3, -1, 14, d);
      check("abort_busy_pre", 32'(busy), 32'd1);
      #3 reset = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(capture_done), 32'd0);
      check("abort_forced", 32'(trig_forced), 32'd0);
      check("abort_rd", 32'(rd_data), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         sample_in = 12'(i * 100); sample_valid = 1'b1;
         tick();
         sample_valid = 1'b0;
      end
      check("idle_after_abort", 32'(busy), 32'd0);
      verify("rerun", 3, -1);

      // Arm during POSTTRIG is ignored; arm in DONE restarts.
      verify("arm_post", 3, 13);
      verify("arm_done", 3, -1);

      // Randomised captures against the model.
      for (int r = 0; r < 3; r++) begin
         trig_level = 12'($urandom_range(3500, 500));
         trig_slope = 1'($urandom_range(1, 0));
         stim.delete();
         for (int i = 0; i < 150; i++) stim.push_back(12'($urandom_range(4095, 0)));
         verify($sformatf("rand%0d", r), 0, -1);
         do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
